// File: rtl/unary_accum_nch.sv
// Multi-channel unary pulse accumulator with an overflow flag and a unary
// readout: a request streams the accumulated count out as a run of dout pulses.
module unary_accum_nch #(
    parameter int N   = 2,
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         read_or_write,
    input  logic [N-1:0] din,
    output logic         dout,
    output logic         C,
    output logic [W-1:0] count,
    output logic         done
);

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_reg;
    logic [W-1:0] rem_reg;
    logic [W:0]   pop_count;
    logic [W:0]   sum;

    // One extra bit so the carry out of the accumulator marks an overflow.
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < N; i++) begin
            pop_count = pop_count + {{W{1'b0}}, din[i]};
        end
        sum = {1'b0, count} + pop_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC;
            count     <= '0;
            rem_reg   <= '0;
            C         <= 1'b0;
            dout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state_reg)
                    ACC: begin
                        if (!read_or_write) begin
                            if (sum[W]) begin
                                C     <= 1'b1;
                                count <= (SAT != 0) ? '1 : sum[W-1:0];
                            end else begin
                                count <= sum[W-1:0];
                            end
                        end else begin
                            rem_reg <= count;
                            if (count != '0) begin
                                state_reg <= EMIT;
                                dout      <= 1'b1;
                            end else begin
                                state_reg <= HOLD;
                                done      <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        // The first pulse was raised on the request edge, so
                        // the last remaining unit ends the run here.
                        if (rem_reg > ONE) begin
                            rem_reg <= rem_reg - ONE;
                        end else begin
                            rem_reg   <= '0;
                            dout      <= 1'b0;
                            state_reg <= HOLD;
                            done      <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!read_or_write) begin
                            state_reg <= ACC;
                            count     <= '0;
                            C         <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ACC;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unary_accum_nch.sv
// Directed bench for unary_accum_nch: a wrapping and a saturating instance share
// stimulus; readouts are checked by a scoreboard monitor on each done pulse.
module tb_unary_accum_nch;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       read_or_write;
    logic [1:0] din;

    logic       dout_a  [2];
    logic       c_a     [2];
    logic [7:0] count_a [2];
    logic       done_a  [2];

    typedef struct {
        int cnt;
        int hi;
        int c;
    } exp_t;

    exp_t exp_q [2][$];
    int   done_seen [2];
    int   hi_cnt [2];
    logic prev_done [2];
    int   checks;
    int   errors;

    // Instance 0 wraps on overflow, instance 1 saturates.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_dut
        unary_accum_nch #(.N(2), .W(8), .SAT(gi)) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .en            (en),
            .read_or_write (read_or_write),
            .din           (din),
            .dout          (dout_a[gi]),
            .C             (c_a[gi]),
            .count         (count_a[gi]),
            .done          (done_a[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic [1:0] d);
        en = e;
        read_or_write = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push_both(input int c0, input int c1, input int cf0, input int cf1);
        exp_t e;
        e.cnt = c0; e.hi = c0; e.c = cf0;
        exp_q[0].push_back(e);
        e.cnt = c1; e.hi = c1; e.c = cf1;
        exp_q[1].push_back(e);
    endtask

    task automatic chk_both(input string name, input int c0, input int c1, input int cf0, input int cf1);
        chk({name, " count0"}, int'(count_a[0]), c0);
        chk({name, " count1"}, int'(count_a[1]), c1);
        chk({name, " C0"}, int'(c_a[0]), cf0);
        chk({name, " C1"}, int'(c_a[1]), cf1);
    endtask

    task automatic wait_done(input int t0, input int t1, input logic r);
        int k;
        k = 0;
        while ((done_seen[0] < t0 || done_seen[1] < t1) && k < 600) begin
            step(1'b1, r, 2'b00);
            k++;
        end
        chk("readout completes in budget", int'(done_seen[0] >= t0 && done_seen[1] >= t1), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_seen = '{0, 0};
        hi_cnt = '{0, 0};
        prev_done = '{1'b0, 1'b0};
        rst_n = 1'b0;
        en = 1'b0;
        read_or_write = 1'b0;
        din = 2'b00;
        fork
            begin : stimulus
                @(posedge clk);
                @(posedge clk);
                #1;
                chk_both("reset", 0, 0, 0, 0);
                for (int i = 0; i < 2; i++) begin
                    chk("reset dout", int'(dout_a[i]), 0);
                    chk("reset done", int'(done_a[i]), 0);
                end
                rst_n = 1'b1;

                // Alternate 11/00: +2 per pair.
                for (int p = 1; p <= 257; p++) begin
                    step(1'b1, 1'b0, 2'b11);
                    step(1'b1, 1'b0, 2'b00);
                    if (p == 127) chk_both("pair127", 254, 254, 0, 0);
                    if (p == 128) chk_both("pair128", 0, 255, 1, 1);
                end
                chk_both("pair257", 2, 255, 1, 1);

                // Readout with the request held: both instances park in HOLD.
                push_both(2, 255, 1, 1);
                step(1'b1, 1'b1, 2'b11);
                chk("request dout0", int'(dout_a[0]), 1);
                wait_done(1, 1, 1'b1);
                step(1'b1, 1'b1, 2'b11);
                chk_both("hold keeps count", 2, 255, 1, 1);
                step(1'b1, 1'b0, 2'b11);
                chk_both("hold to acc", 0, 0, 0, 0);

                // Accumulate to 5 with a disabled cycle in between.
                step(1'b1, 1'b0, 2'b11);
                step(1'b0, 1'b0, 2'b11);
                chk_both("en low holds", 2, 2, 0, 0);
                step(1'b1, 1'b0, 2'b01);
                step(1'b1, 1'b0, 2'b10);
                step(1'b1, 1'b0, 2'b00);
                step(1'b1, 1'b0, 2'b01);
                chk_both("acc5", 5, 5, 0, 0);
                push_both(5, 5, 0, 0);
                step(1'b1, 1'b1, 2'b11);
                chk("readout5 first dout", int'(dout_a[1]), 1);
                wait_done(2, 2, 1'b0);
                chk_both("after readout5", 0, 0, 0, 0);

                // Zero readout: done on the edge after the request, no pulse.
                push_both(0, 0, 0, 0);
                step(1'b1, 1'b1, 2'b11);
                chk("zero readout done", int'(done_a[0]), 1);
                chk("zero readout dout", int'(dout_a[0]), 0);
                step(1'b1, 1'b0, 2'b00);
                wait_done(3, 3, 1'b0);

                // Count 10 with en dropped for 3 cycles mid-readout.
                for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b11);
                chk_both("acc10", 10, 10, 0, 0);
                push_both(10, 10, 0, 0);
                step(1'b1, 1'b1, 2'b00);
                for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00);
                for (int i = 0; i < 3; i++) begin
                    step(1'b0, 1'b0, 2'b00);
                    chk("frozen dout", int'(dout_a[0]), 1);
                    chk("frozen done", int'(done_a[0]), 0);
                end
                wait_done(4, 4, 1'b0);

                // Overflow, start a readout, then reset mid-readout.
                for (int i = 0; i < 130; i++) step(1'b1, 1'b0, 2'b11);
                chk_both("acc260", 4, 255, 1, 1);
                step(1'b1, 1'b1, 2'b00);
                step(1'b1, 1'b0, 2'b00);
                step(1'b1, 1'b0, 2'b00);
                #2;
                rst_n = 1'b0;
                #1;
                chk_both("async reset", 0, 0, 0, 0);
                chk("async reset dout0", int'(dout_a[0]), 0);
                chk("async reset dout1", int'(dout_a[1]), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                step(1'b1, 1'b0, 2'b01);
                chk_both("first acc after reset", 1, 1, 0, 0);
                chk("leftover expected 0", exp_q[0].size(), 0);
                chk("leftover expected 1", exp_q[1].size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        hi_cnt = '{0, 0};
                        prev_done = '{1'b0, 1'b0};
                    end else begin
                        for (int i = 0; i < 2; i++) begin
                            if (done_a[i]) begin
                                chk("done single cycle", int'(prev_done[i]), 0);
                                chk("dout low at done", int'(dout_a[i]), 0);
                                if (exp_q[i].size() == 0) begin
                                    chk("unexpected done", 1, 0);
                                end else begin
                                    exp_t e;
                                    e = exp_q[i].pop_front();
                                    $display("readout dut%0d: count=%0d pulses=%0d C=%0d", i, count_a[i], hi_cnt[i], c_a[i]);
                                    chk("readout count", int'(count_a[i]), e.cnt);
                                    chk("readout pulses", hi_cnt[i], e.hi);
                                    chk("readout C", int'(c_a[i]), e.c);
                                end
                                hi_cnt[i] = 0;
                                done_seen[i]++;
                            end else if (dout_a[i] && en) begin
                                hi_cnt[i]++;
                            end
                            prev_done[i] = done_a[i];
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
